// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states, default geometry
// and the fetch-address field layout.
package icache_pkg;

    localparam int DEF_LINES  = 64;
    localparam int DEF_WORDS  = 4;
    localparam int DEF_WSEL_W = $clog2(DEF_WORDS);
    localparam int DEF_IDX_W  = $clog2(DEF_LINES);
    localparam int DEF_TAG_W  = 30 - DEF_WSEL_W - DEF_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESPOND
    } state_t;

    // Byte address split at the default geometry: tag | index | word select | byte offset.
    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_IDX_W-1:0]  index;
        logic [DEF_WSEL_W-1:0] wsel;
        logic [1:0]            byte_off;
    } addr_fields_t;

endpackage

// File: rtl/icache_data_ram.sv
// Single-port synchronous RAM: one write port, registered read with 1-cycle latency.
// Used for both the line data array and the tag array of the instruction cache.
module icache_data_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the array has no reset; line validity lives in separately reset flops.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line sequential refill and flush.
// Optional `ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    output logic        fe_ack,
    output logic [31:0] fe_data,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WSEL_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - WSEL_W - IDX_W;

    state_t                  r_state;
    logic [29:0]             r_addr;
    logic [WSEL_W-1:0]       r_cnt;
    logic                    r_fill_done;
    logic                    r_flushed;
    logic [LINES-1:0]        r_valid;
    logic [WORDS-1:0][31:0]  r_buf;

    logic [WSEL_W-1:0]       w_wsel;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_ram_addr;
    logic [TAG_W-1:0]        w_tag_rd;
    logic [WORDS-1:0][31:0]  w_line_rd;
    logic                    w_accept;
    logic                    w_write;
    logic                    w_hit;
    logic                    w_unused_addr;

    assign w_wsel        = r_addr[WSEL_W-1:0];
    assign w_idx         = r_addr[WSEL_W +: IDX_W];
    assign w_tag         = r_addr[29 -: TAG_W];
    assign w_unused_addr = ^fe_addr[1:0];

    assign w_accept   = (r_state == S_IDLE) && fe_req && !flush;
    assign w_write    = (r_state == S_REFILL) && r_fill_done;
    assign w_ram_addr = w_write ? w_idx : fe_addr[2+WSEL_W +: IDX_W];
    assign w_hit      = r_valid[w_idx] && (w_tag_rd == w_tag);

    icache_data_ram #(.DEPTH(LINES), .WIDTH(WORDS*32)) u_data_ram (
        .clk     (clk),
        .i_we    (w_write),
        .i_re    (w_accept),
        .i_addr  (w_ram_addr),
        .i_wdata (r_buf),
        .o_rdata (w_line_rd)
    );

    icache_data_ram #(.DEPTH(LINES), .WIDTH(TAG_W)) u_tag_ram (
        .clk     (clk),
        .i_we    (w_write),
        .i_re    (w_accept),
        .i_addr  (w_ram_addr),
        .i_wdata (w_tag),
        .o_rdata (w_tag_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_fill_done <= 1'b0;
            r_flushed   <= 1'b0;
            r_valid     <= '0;
        end else begin
            if (flush) r_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= fe_addr[31:2];
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state     <= S_REFILL;
                        r_cnt       <= '0;
                        r_fill_done <= 1'b0;
                        r_flushed   <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (flush) r_flushed <= 1'b1;
                    if (r_fill_done) begin
                        // A flush seen anywhere in the refill keeps the new line invalid.
                        if (!(flush || r_flushed)) r_valid[w_idx] <= 1'b1;
                        r_fill_done <= 1'b0;
                        r_state     <= S_RESPOND;
                    end else if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) r_fill_done <= 1'b1;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_REFILL) && !r_fill_done && mem_ack) r_buf[r_cnt] <= mem_data;
    end

    assign fe_ack   = ((r_state == S_LOOKUP) && w_hit) || (r_state == S_RESPOND);
    assign mem_req  = (r_state == S_REFILL) && !r_fill_done;
    assign mem_addr = {r_addr[29:WSEL_W], r_cnt, 2'b00};

    // NOTE: default first so every path assigns fe_data and no latch is inferred.
    always_comb begin
        fe_data = '0;
        if ((r_state == S_LOOKUP) && w_hit) fe_data = w_line_rd[w_wsel];
        else if (r_state == S_RESPOND)      fe_data = r_buf[w_wsel];
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
            end else begin
                if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between `stage_fetch` and the `memory` block. It serves fetch requests from on-chip tag/data arrays and refills whole lines from `memory` on a miss, one word per handshake. A `flush` input invalidates all lines, which is how `fence.i` is supported.

## Interface
Parameters:
- `LINES`, 64: number of lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `fe_req`  in  1: fetch request, level; `fe_addr` stable while high until `fe_ack`.
- `fe_addr`  in  32: fetch byte address; bits [1:0] ignored.
- `fe_ack`  out  1: one-cycle pulse; `fe_data` valid this cycle.
- `fe_data`  out  32: instruction word.
- `flush`  in  1: invalidate all lines.
- `mem_req`  out  1: refill word request, held until `mem_ack`.
- `mem_addr`  out  32: word-aligned refill address.
- `mem_ack`  in  1: one-cycle pulse; `mem_data` valid.
- `mem_data`  in  32: refill word.

## Operation
- Address split:
  - word select = [2+log2(WORDS)-1:2].
  - index = next log2(LINES) bits.
  - tag = remaining upper bits. With the defaults: index [9:4], tag [31:10].
- Per line: valid bit (flops), tag, and WORDS data words.
- FSM states: IDLE, LOOKUP, REFILL, RESPOND.
  - IDLE: if `fe_req` and not `flush`, latch the address, start the synchronous array read, go to LOOKUP.
  - LOOKUP:
    - On a hit (valid and tag match), assert `fe_ack` with the selected word, then go to IDLE.
    - On a miss, go to REFILL with word counter = 0.
  - REFILL:
    - `mem_req`=1 and `mem_addr` = {tag, index, counter, 2'b00}.
    - On each `mem_ack`, store `mem_data` in the refill buffer and increment the counter.
    - The counter wraps at WORDS. After the last ack, write tag, data and valid together, then go to RESPOND.
  - RESPOND: `fe_ack`=1 with the requested word from the refill buffer, then go to IDLE.
- Line fill always starts at word 0 and is sequential; no critical-word-first.
- `flush`:
  - Clears all valid bits in one cycle.
  - Priority over a request in the same cycle; that request is accepted in the next cycle.
  - A flush during REFILL or RESPOND lets the refill complete and the response is still delivered, but the line is not marked valid.
- `reset` (including mid-refill): state goes to IDLE, all valid bits are cleared, `mem_req` deasserts the next cycle, and any in-flight `mem_ack` is ignored.
- `fe_req` dropped without an ack is illegal; behaviour is undefined.

## Timing
- Reset values:
  - `fe_ack`=0, `fe_data`=0, `mem_req`=0, `mem_addr`=0.
  - All valid bits 0, state IDLE, counters 0.
- Hit: `fe_req` sampled high at edge N, so `fe_ack` is high during cycle N+1. Maximum throughput is one fetch per 2 cycles.
- Miss:
  - `mem_req` rises in cycle N+2.
  - `mem_addr` advances in the cycle after each `mem_ack`, and `mem_req` stays high between words.
  - `fe_ack` is asserted 1 cycle after the final `mem_ack`'s array write cycle: final ack at cycle M gives a write at M+1 and `fe_ack` at M+2.
- `mem_req` falls in the cycle after the last `mem_ack`.
- `fe_ack` never asserts in two consecutive cycles.

## Configuration
- `ICACHE_STATS_EN` defined: adds output ports `hit_count` (32) and `miss_count` (32).
  - Each is incremented on a LOOKUP hit or miss respectively.
  - Each saturates at 0xFFFFFFFF.
  - Cleared by `reset`, not by `flush`.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `icache_pkg`: state enum (IDLE/LOOKUP/REFILL/RESPOND), field-width localparams derived from `LINES`/`WORDS`, and a packed address-field struct.
- Sub-module `icache_data_ram`: synchronous-read, single-write-port array of LINES×WORDS×32, with a 1-cycle read latency. The tag array is a second instance or a flop array; valid bits are flops.

## Test plan
- Cold miss:
  - Stimulus: after reset, fetch 0x0000_0104.
  - Expect `mem_addr` 0x100, 0x104, 0x108, 0x10C in order.
  - `fe_data` equals the word returned for 0x104; `fe_ack` 2 cycles after the 4th `mem_ack`.
- Hit:
  - Stimulus: fetch 0x108 after the cold-miss refill.
  - Expect `fe_ack` at N+1 with the correct word, and `mem_req` stays 0.
- Conflict:
  - Stimulus: fetch 0x100, then 0x500 (same index, different tag), then 0x100.
  - Expect three refills, each returning the correct data.
- Flush:
  - Stimulus: fill 0x100; pulse `flush`; fetch 0x100.
  - Expect a refill.
  - Also: `flush` asserted mid-refill gives correct data, and the next fetch of the same line misses again.
- Reset mid-refill:
  - Stimulus: assert `reset` after 2 `mem_ack`s.
  - Expect `mem_req`=0 the next cycle and no `fe_ack`; a refetch performs a full 4-word refill.
- `ICACHE_STATS_EN`:
  - Stimulus: miss, hit, hit.
  - Expect `hit_count`=2 and `miss_count`=1.
